// File: rtl/ram_1w_nr_clr.sv
// ram_1w_nr_clr: one-write / N-read register-file RAM with a hardware clear.
// Optional per-lane even parity and par_inj port: define RAM_1W_NR_CLR_PARITY_EN.
module ram_1w_nr_clr #(
  parameter int WORD_COUNT  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int RD_PORTS    = 2,
  parameter int MASK_WIDTH  = 1,
  parameter int SYNC_READ   = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef RAM_1W_NR_CLR_PARITY_EN
  input  logic                           par_inj,
`endif
  input  logic                           clr_req,
  output logic                           clr_busy,
  input  logic                           wr_en,
  input  logic [MASK_WIDTH-1:0]          wr_mask,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [WORD_WIDTH-1:0]          wr_data,
  output logic                           wr_drop,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*WORD_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_perr
);

  localparam int LW = WORD_WIDTH / MASK_WIDTH;
  localparam int IW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [ADDR_WIDTH:0]   LP_WC   = (ADDR_WIDTH+1)'(WORD_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(WORD_COUNT - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nx;
  logic                  r_wr_drop;

  logic [WORD_WIDTH-1:0] r_mem [WORD_COUNT];

  logic                  w_wr_in;
  logic                  w_wr_ok;
  logic [IW-1:0]         w_wr_idx;
  logic [IW-1:0]         w_clr_idx;
  logic [WORD_WIDTH-1:0] w_wr_old;
  logic [WORD_WIDTH-1:0] w_wr_merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_clr_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clr_cnt_nx = r_clr_cnt;
    unique case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == LP_LAST) begin
          w_state_nx   = ST_IDLE;
          w_clr_cnt_nx = '0;
        end else begin
          w_clr_cnt_nx = r_clr_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nx   = ST_CLEAR;
          w_clr_cnt_nx = '0;
        end
      end
      default: begin
        w_state_nx   = ST_CLEAR;
        w_clr_cnt_nx = '0;
      end
    endcase
  end

  assign clr_busy = (r_state == ST_CLEAR);

  assign w_wr_in   = ({1'b0, wr_addr} < LP_WC);
  assign w_wr_ok   = wr_en & ~clr_busy & w_wr_in;
  assign w_wr_idx  = wr_addr[IW-1:0];
  assign w_clr_idx = r_clr_cnt[IW-1:0];
  assign w_wr_old  = w_wr_in ? r_mem[w_wr_idx] : '0;

  always_comb begin
    w_wr_merge = w_wr_old;
    for (int l = 0; l < MASK_WIDTH; l++) begin
      if (wr_mask[l]) begin
        w_wr_merge[l*LW +: LW] = wr_data[l*LW +: LW];
      end
    end
  end

  // The array has no reset; the clear sequencer owns it while busy.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_wr_idx] <= w_wr_merge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en & (clr_busy | ~w_wr_in);
    end
  end

  assign wr_drop = r_wr_drop;

`ifdef RAM_1W_NR_CLR_PARITY_EN
  logic [MASK_WIDTH-1:0] r_par [WORD_COUNT];
  logic [MASK_WIDTH-1:0] w_wr_pold;
  logic [MASK_WIDTH-1:0] w_wr_pnew;
  logic [MASK_WIDTH-1:0] w_wr_pmerge;

  function automatic logic [MASK_WIDTH-1:0] lane_par(
    input logic [WORD_WIDTH-1:0] d
  );
    logic [MASK_WIDTH-1:0] r;
    for (int l = 0; l < MASK_WIDTH; l++) begin
      r[l] = ^d[l*LW +: LW];
    end
    return r;
  endfunction

  assign w_wr_pold = w_wr_in ? r_par[w_wr_idx] : '0;

  always_comb begin
    w_wr_pnew    = lane_par(wr_data);
    w_wr_pnew[0] = w_wr_pnew[0] ^ par_inj;
    w_wr_pmerge  = w_wr_pold;
    for (int l = 0; l < MASK_WIDTH; l++) begin
      if (wr_mask[l]) begin
        w_wr_pmerge[l] = w_wr_pnew[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_busy) begin
      r_par[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_par[w_wr_idx] <= w_wr_pmerge;
    end
  end
`endif

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [IW-1:0]         w_ridx;
    logic                  w_rin;
    logic                  w_hit;
    logic [WORD_WIDTH-1:0] w_rv;
    logic                  w_rpe;

    assign w_ra   = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_ridx = w_ra[IW-1:0];
    assign w_rin  = ({1'b0, w_ra} < LP_WC);
    assign w_hit  = (WRITE_FIRST != 0) && w_wr_ok && (wr_addr == w_ra);

    // Busy or out-of-range reads return zero; bypass only on an accepted write.
    always_comb begin
      w_rv = '0;
      if (!clr_busy && w_rin) begin
        w_rv = w_hit ? w_wr_merge : r_mem[w_ridx];
      end
    end

`ifdef RAM_1W_NR_CLR_PARITY_EN
    logic [MASK_WIDTH-1:0] w_rpar;

    always_comb begin
      w_rpar = '0;
      if (!clr_busy && w_rin) begin
        w_rpar = w_hit ? w_wr_pmerge : r_par[w_ridx];
      end
    end

    assign w_rpe = |(lane_par(w_rv) ^ w_rpar);
`else
    assign w_rpe = 1'b0;
`endif

    if (SYNC_READ != 0) begin : g_sync
      logic [WORD_WIDTH-1:0] r_rd;
      logic                  r_pe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd <= '0;
          r_pe <= 1'b0;
        end else if (rd_en[p]) begin
          r_rd <= w_rv;
          r_pe <= w_rpe;
        end
      end

      assign rd_data[p*WORD_WIDTH +: WORD_WIDTH] = r_rd;
      assign rd_perr[p] = r_pe;
    end else begin : g_comb
      logic w_unused_en;

      assign w_unused_en = rd_en[p];
      assign rd_data[p*WORD_WIDTH +: WORD_WIDTH] = w_rv;
      assign rd_perr[p] = w_rpe;
    end
  end

endmodule

// File: doc/ram_1w_nr_clr.md
Name: ram_1w_nr_clr

Overview:
- Parametrised one-write / N-read register-file RAM; next generation of the core register-file memory.
- Adds per-lane write masks, selectable asynchronous or registered reads, and defined read-under-write behaviour.
- A hardware clear sequencer zeroes every word after reset or on request, because the array itself cannot be async-reset.
- Sits under CPU register files and small peripheral tables.

Parameters:
- WORD_COUNT, 32, number of words; must satisfy WORD_COUNT <= 2**ADDR_WIDTH.
- WORD_WIDTH, 32, data bits per word.
- ADDR_WIDTH, 5, address bits, shared by write and read ports.
- RD_PORTS, 2, number of independent read ports, 1..4.
- MASK_WIDTH, 1, write-mask lanes; each lane covers WORD_WIDTH/MASK_WIDTH bits, and the division must be exact.
- SYNC_READ, 0, 0 = combinational read, 1 = registered read with 1-cycle latency.
- WRITE_FIRST, 0, 0 = reads in the write cycle return old data, 1 = they return newly merged data (bypass).

Ports:
- clk  in  1  Clock, rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- clr_req  in  1  Single-cycle pulse; starts a full clear.
- clr_busy  out  1  High while the clear sequencer runs.
- wr_en  in  1  Write strobe.
- wr_mask  in  MASK_WIDTH  Lane enables for the write.
- wr_addr  in  ADDR_WIDTH  Write address.
- wr_data  in  WORD_WIDTH  Write data.
- wr_drop  out  1  One-cycle pulse when a write is discarded.
- rd_en  in  RD_PORTS  Per-port read enable; used only when SYNC_READ=1.
- rd_addr  in  RD_PORTS*ADDR_WIDTH  Packed read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  RD_PORTS*WORD_WIDTH  Packed read data, same packing.
- rd_perr  out  RD_PORTS  Per-port parity error; see Optional Feature.

Behaviour:
- Reset: rst_n low asynchronously sets FSM=CLEAR, clr_cnt=0, clr_busy=1, wr_drop=0, every registered rd_data word=0, rd_perr=0. Array contents are not reset.
- FSM states:
  - CLEAR: each cycle writes zero (parity 0) to word clr_cnt, then clr_cnt increments. After the edge that writes word WORD_COUNT-1, FSM goes to IDLE. clr_busy is high for exactly WORD_COUNT cycles after reset release.
  - IDLE: clr_busy=0. clr_req=1 sets FSM=CLEAR and clr_cnt=0 at the next edge.
  - clr_req during CLEAR is ignored; the sequence is not restarted.
  - Reset asserted mid-clear restarts the clear from word 0.
- Writes, IDLE only: on the edge with wr_en=1 and wr_addr<WORD_COUNT, each lane L with wr_mask[L]=1 takes wr_data lane L; other lanes keep their value. wr_mask=0 with wr_en=1 is a legal no-op.
- Dropped writes: wr_en=1 while clr_busy=1, or wr_addr>=WORD_COUNT, leaves the array unchanged and pulses wr_drop for one cycle, registered.
- Reads, SYNC_READ=0:
  - rd_data[p] = mem[rd_addr[p]] combinationally; rd_en is ignored.
  - A write is visible the cycle after its edge.
  - With WRITE_FIRST=1, same-cycle address match returns the masked merge of wr_data over the stored word, combinationally.
- Reads, SYNC_READ=1:
  - On an edge with rd_en[p]=1, the port-p register loads mem[rd_addr[p]]; it holds when rd_en[p]=0.
  - Same-edge write to the same address: WRITE_FIRST=0 loads the old word; WRITE_FIRST=1 loads the merged new word.
- Reads while clr_busy=1: every port returns 0 (combinational) or loads 0 (registered).
- Out-of-range read address (>= WORD_COUNT): data returns 0.
- Ports are fully independent; any number may target the same address.

Optional Feature:
- Macro: RAM_1W_NR_CLR_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per mask lane; it is updated only for written lanes and cleared to 0 by the sequencer.
  - rd_perr[p] is the OR of lane parity mismatches for the returned word, with the same timing as rd_data[p]. In bypass cases, parity is computed from the merged data.
  - An extra input, par_inj, of width 1 inverts the stored parity bit of lane 0 on writes, for test.
- Undefined: no parity storage, no par_inj port, rd_perr tied 0.

Test Plan:
- Release reset with WORD_COUNT=32 -> clr_busy high for exactly 32 cycles. Then every word reads 0 on all ports.
- MASK_WIDTH=4: write 0xAABBCCDD to addr 3 with mask 4'b1111, then 0x11223344 with mask 4'b0101 -> addr 3 reads 0xAA22CC44.
- SYNC_READ=1, WRITE_FIRST=0/1: write 0x5 to addr 7 while rd_en[0]=1 and rd_addr0=7 on the same edge (old value 0x9) -> next cycle rd_data0 = 0x9 / 0x5 respectively; port 1 on addr 7 matches.
- Pulse clr_req, then wr_en=1 to addr 2 during clear -> wr_drop pulses, and addr 2 reads 0 after clr_busy falls. A second clr_req mid-clear does not extend clr_busy beyond 32 cycles.
- Assert rst_n low at clear cycle 10 -> clr_busy stays high, and the clear restarts with a full 32 cycles after release.
- With RAM_1W_NR_CLR_PARITY_EN: write 0x0000_00FF with par_inj=1 to addr 1, then read it -> rd_perr=1. Rewrite with par_inj=0 -> rd_perr=0.
